// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_subtractor_ctrl                                       |
// | Description : Bit-serial WIDTH-bit subtractor controller (diff = a - b)    |
// |               that time-shares one external 1-bit full subtractor, LSB    |
// |               first. Optional macro SUB_OVERFLOW_EN adds the ovf output.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_bin,
  input  logic             fs_d,
  input  logic             fs_bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
`ifdef SUB_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        res_sh_d = {fs_d, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = fs_bout;
        if (cnt_q == CNT_LAST) begin
          // Result is committed with the final bit so diff is valid while done is high.
          diff_d  = res_sh_d;
          bout_d  = fs_bout;
`ifdef SUB_OVERFLOW_EN
          ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_DONE);
    fs_a   = (state_q == ST_RUN) & a_sh_q[0];
    fs_b   = (state_q == ST_RUN) & b_sh_q[0];
    fs_bin = (state_q == ST_RUN) & borrow_q;
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf        = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_serial_subtractor_ctrl                                    |
// | Description : Scoreboard bench for serial_subtractor_ctrl with an inline   |
// |               1-bit full subtractor on the fs_* pins.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_serial_subtractor_ctrl;
  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [WIDTH-1:0] a, b, diff;
  logic             busy, done, borrow_out;
  logic             fs_a, fs_b, fs_bin, fs_d, fs_bout;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  exp_t             sb_q[$];
  int               total = 0;
  int               bad   = 0;
  logic [WIDTH-1:0] last_d;

  always #5 clk = ~clk;

  assign fs_d    = fs_a ^ fs_b ^ fs_bin;
  assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out),
`ifdef SUB_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .fs_a      (fs_a),
    .fs_b      (fs_b),
    .fs_bin    (fs_bin),
    .fs_d      (fs_d),
    .fs_bout   (fs_bout)
  );

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    int   rs;
    e.d  = x - y;
    e.bo = (x < y);
    rs   = int'($signed(x)) - int'($signed(y));
    e.ov = (rs > (2 ** (WIDTH - 1)) - 1) || (rs < -(2 ** (WIDTH - 1)));
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("diff", diff, e.d);
        check("borrow_out", borrow_out, e.bo);
`ifdef SUB_OVERFLOW_EN
        check("ovf", ovf, e.ov);
`endif
        last_d = e.d;
      end
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input bit hold, input bit mid_aa);
    int n;
    bit got;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_fs", {fs_a, fs_b, fs_bin}, 0);
    check("diff_hold", diff, last_d);
    start = 1'b1;
    a     = x;
    b     = y;
    sb_q.push_back(model(x, y));
    n   = 0;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (!hold) start = 1'b0;
      a = mid_aa ? WIDTH'(8'hAA) : WIDTH'($urandom);
      b = mid_aa ? WIDTH'(8'hAA) : WIDTH'($urandom);
      if (done) got = 1;
      else check("busy_run", busy, 1);
    end
    check("latency", n, WIDTH + 1);
    if (got) check("busy_done", busy, 1);
    start = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    last_d = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 0, 0);
    run_op(8'h03, 8'h05, 0, 0);
    run_op(8'hFF, 8'h01, 0, 0);
    run_op(8'h00, 8'h00, 0, 0);
    run_op(8'h10, 8'h01, 1, 1);
`ifdef SUB_OVERFLOW_EN
    run_op(8'h80, 8'h01, 0, 0);
    run_op(8'h05, 8'h03, 0, 0);
`endif

    // Reset during RUN cycle 4 must abort without a done pulse.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h21;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow_out, 0);
    rst_n  = 1'b1;
    last_d = '0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), bit'($urandom_range(0, 1)), 0);
    end
    run_op(8'h00, 8'hFF, 0, 0);
    run_op(8'h7F, 8'h80, 0, 0);

    repeat (4) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
